// File: rtl/bubble_sort_ctrl.sv
// In-place bubble sort of the first len_i words of an external true-dual-port RAM.
// Ascending or descending order, early exit on a swap-free pass, RAM read latency of 1 to 4 cycles.
module bubble_sort_ctrl #(
  parameter int DWIDTH  = 10,
  parameter int ADDR_SZ = 10,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 20
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               start_i,
  input  logic               descending_i,
  input  logic [ADDR_SZ-1:0] len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDR_SZ-1:0] address_a,
  output logic [ADDR_SZ-1:0] address_b,
  output logic [DWIDTH-1:0]  data_a,
  output logic [DWIDTH-1:0]  data_b,
  output logic               wren_a,
  output logic               wren_b,
  input  logic [DWIDTH-1:0]  q_a,
  input  logic [DWIDTH-1:0]  q_b,
  output logic [ADDR_SZ-1:0] passes_o,
  output logic [CNT_W-1:0]   swaps_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  // WAIT holds RD_LAT-1 cycles; the counter runs down to zero.
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t             state_q, state_d;
  logic [ADDR_SZ-1:0] index_q, index_d;
  logic [ADDR_SZ-1:0] last_q, last_d;
  logic [ADDR_SZ-1:0] addr_b_q, addr_b_d;
  logic [ADDR_SZ-1:0] passes_q, passes_d;
  logic [CNT_W-1:0]   swaps_q, swaps_d;
  logic [1:0]         wait_q, wait_d;
  logic               swapped_q, swapped_d;
  logic               desc_q, desc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               swap_now;
  logic [ADDR_SZ:0]   idx_inc;

  // Equal values never swap, which keeps the sort stable.
  assign swap_now = (state_q == S_CMP) && (desc_q ? (q_a < q_b) : (q_a > q_b));
  // One bit wider so the end-of-pass test cannot wrap at the maximum length.
  assign idx_inc  = {1'b0, index_q} + {{ADDR_SZ{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every _d defaults to its _q so no path through the case infers a latch.
    state_d   = state_q;
    index_d   = index_q;
    last_d    = last_q;
    passes_d  = passes_q;
    swaps_d   = swaps_q;
    wait_d    = wait_q;
    swapped_d = swapped_q;
    desc_d    = desc_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          desc_d    = descending_i;
          last_d    = len_i - ADDR_SZ'(1);
          index_d   = '0;
          swapped_d = 1'b0;
          passes_d  = '0;
          swaps_d   = '0;
          state_d   = (len_i <= ADDR_SZ'(1)) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (RD_LAT == 1) begin
          state_d = S_CMP;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) state_d = S_CMP;
        else                wait_d  = wait_q - 2'd1;
      end
      S_CMP: begin
        if (swap_now) begin
          swapped_d = 1'b1;
          if (swaps_q != '1) swaps_d = swaps_q + CNT_W'(1);
        end
        if (idx_inc < {1'b0, last_q}) begin
          index_d = idx_inc[ADDR_SZ-1:0];
          state_d = S_READ;
        end else begin
          passes_d = passes_q + ADDR_SZ'(1);
          if (last_q == ADDR_SZ'(1) || !(swapped_q || swap_now)) begin
            state_d = S_DONE;
          end else begin
            last_d    = last_q - ADDR_SZ'(1);
            index_d   = '0;
            swapped_d = 1'b0;
            state_d   = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the next state so they line up with it.
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    addr_b_d = index_d + ADDR_SZ'(1);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking updates make every flop sample the same pre-edge values.
    if (srst_i) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      last_q    <= '0;
      addr_b_q  <= ADDR_SZ'(1);
      passes_q  <= '0;
      swaps_q   <= '0;
      wait_q    <= 2'd0;
      swapped_q <= 1'b0;
      desc_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      last_q    <= last_d;
      addr_b_q  <= addr_b_d;
      passes_q  <= passes_d;
      swaps_q   <= swaps_d;
      wait_q    <= wait_d;
      swapped_q <= swapped_d;
      desc_q    <= desc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Write-back depends on this cycle's read data, so the write port is decoded from state and q.
  assign wren_a    = swap_now;
  assign wren_b    = swap_now;
  assign data_a    = swap_now ? q_b : q_a;
  assign data_b    = swap_now ? q_a : q_b;

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign address_a = index_q;
  assign address_b = addr_b_q;
  assign passes_o  = passes_q;
  assign swaps_o   = swaps_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: RD_LAT=1 and RD_LAT=3 instances, each on its own registered-read RAM model.
// Table vectors and a reference sort feed a scoreboard that is checked on every done_o.
module tb_bubble_sort_ctrl;
  localparam int DW    = 10;
  localparam int AW    = 10;
  localparam int CW    = 20;
  localparam int BOUND = 20000;
  localparam int NV    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst;
  logic          start [2];
  logic          desc;
  logic [AW-1:0] len;
  logic          busy [2], done [2], wren_a [2], wren_b [2];
  logic [AW-1:0] addr_a [2], addr_b [2], passes [2];
  logic [DW-1:0] data_a [2], data_b [2], q_a [2], q_b [2];
  logic [CW-1:0] swaps [2];

  bubble_sort_ctrl #(.DWIDTH(DW), .ADDR_SZ(AW), .RD_LAT(1), .CNT_W(CW)) u_lat1 (
    .clk_i(clk), .srst_i(srst), .start_i(start[0]), .descending_i(desc), .len_i(len),
    .busy_o(busy[0]), .done_o(done[0]), .address_a(addr_a[0]), .address_b(addr_b[0]),
    .data_a(data_a[0]), .data_b(data_b[0]), .wren_a(wren_a[0]), .wren_b(wren_b[0]),
    .q_a(q_a[0]), .q_b(q_b[0]), .passes_o(passes[0]), .swaps_o(swaps[0]));

  bubble_sort_ctrl #(.DWIDTH(DW), .ADDR_SZ(AW), .RD_LAT(3), .CNT_W(CW)) u_lat3 (
    .clk_i(clk), .srst_i(srst), .start_i(start[1]), .descending_i(desc), .len_i(len),
    .busy_o(busy[1]), .done_o(done[1]), .address_a(addr_a[1]), .address_b(addr_b[1]),
    .data_a(data_a[1]), .data_b(data_b[1]), .wren_a(wren_a[1]), .wren_b(wren_b[1]),
    .q_a(q_a[1]), .q_b(q_b[1]), .passes_o(passes[1]), .swaps_o(swaps[1]));

  // RAMs with registered address; RD_LAT cycles from address to q.
  logic [DW-1:0] mem [2][1024];
  logic          ld_en, ld_k;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] ra1, rb1;
  logic [DW-1:0] ra3 [3], rb3 [3];

  always @(posedge clk) begin
    if (ld_en) mem[ld_k][ld_addr] <= ld_data;
    for (int k = 0; k < 2; k++) begin
      if (wren_a[k]) mem[k][addr_a[k]] <= data_a[k];
      if (wren_b[k]) mem[k][addr_b[k]] <= data_b[k];
    end
    ra1    <= mem[0][addr_a[0]];
    rb1    <= mem[0][addr_b[0]];
    ra3[0] <= mem[1][addr_a[1]];
    rb3[0] <= mem[1][addr_b[1]];
    ra3[1] <= ra3[0];
    rb3[1] <= rb3[0];
    ra3[2] <= ra3[1];
    rb3[2] <= rb3[1];
  end
  assign q_a[0] = ra1;
  assign q_b[0] = rb1;
  assign q_a[1] = ra3[2];
  assign q_b[1] = rb3[2];

  int done_cnt [2];
  int eq_wr   = 0;
  int ab_mis  = 0;
  int idle_wr = 0;
  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      if (wren_a[k] === 1'b1 && data_a[k] == data_b[k]) eq_wr <= eq_wr + 1;
      if (wren_a[k] !== wren_b[k]) ab_mis <= ab_mis + 1;
      if (wren_a[k] === 1'b1 && busy[k] !== 1'b1) idle_wr <= idle_wr + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int passes;
    int swaps;
    int lat;
  } exp_t;
  exp_t exp_q [$];
  int   exp_mem [32];
  int   stage [32];
  int   mdl [32];

  typedef struct packed {
    logic                 k;
    logic                 d;
    logic [AW-1:0]        n;
    logic [1:0]           poke;
    logic [0:7][DW-1:0]   init;
    logic [0:7][DW-1:0]   expv;
    logic [15:0]          p;
    logic [15:0]          s;
    logic [15:0]          lat;
  } vec_t;
  vec_t tbl [NV];

  function automatic logic [0:7][DW-1:0] w5(input int a, input int b, input int c,
                                             input int d, input int e);
    logic [0:7][DW-1:0] r;
    r    = '0;
    r[0] = DW'(a);
    r[1] = DW'(b);
    r[2] = DW'(c);
    r[3] = DW'(d);
    r[4] = DW'(e);
    return r;
  endfunction

  function automatic vec_t mk(input int k, input int d, input int n, input int poke,
                              input logic [0:7][DW-1:0] init, input logic [0:7][DW-1:0] expv,
                              input int p, input int s, input int lat);
    vec_t v;
    v.k = k[0]; v.d = d[0]; v.n = AW'(n); v.poke = poke[1:0];
    v.init = init; v.expv = expv;
    v.p = p[15:0]; v.s = s[15:0]; v.lat = lat[15:0];
    return v;
  endfunction

  // Reference: textbook bubble sort with a shrinking pass and swap-free early exit.
  task automatic model_sort(input bit d, input int n, output int p, output int s, output int c);
    int  last, t;
    bit  sw, fin;
    p = 0; s = 0; c = 0;
    if (n <= 1) return;
    last = n - 1;
    fin  = 1'b0;
    while (!fin) begin
      sw = 1'b0;
      for (int i = 0; i < last; i++) begin
        c++;
        if (d ? (mdl[i] < mdl[i+1]) : (mdl[i] > mdl[i+1])) begin
          t = mdl[i]; mdl[i] = mdl[i+1]; mdl[i+1] = t;
          s++;
          sw = 1'b1;
        end
      end
      p++;
      if (last == 1 || !sw) fin = 1'b1;
      else last--;
    end
  endtask

  task automatic load_ram(input int k);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_k = k[0]; ld_addr = AW'(i); ld_data = DW'(stage[i]);
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // poke: 1 = extra start while busy, 2 = start during the done_o cycle.
  task automatic run_sort(input string tag, input int k, input bit d, input int n,
                          input int poke, input bit use_model, input int tp, input int ts,
                          input int tl, input logic [0:7][DW-1:0] ev);
    exp_t e;
    int   c, lat, d0, bad;
    bit   seen;
    d0 = done_cnt[k];
    if (use_model) begin
      for (int i = 0; i < 32; i++) mdl[i] = int'(mem[k][i]);
      model_sort(d, n, e.passes, e.swaps, c);
      e.lat = c * ((k == 0) ? 2 : 4) + 1;
      for (int i = 0; i < 32; i++) exp_mem[i] = mdl[i];
    end else begin
      e.passes = tp; e.swaps = ts; e.lat = tl;
      for (int i = 0; i < 32; i++) exp_mem[i] = (i < 8) ? int'(ev[i]) : int'(mem[k][i]);
    end
    exp_q.push_back(e);

    @(negedge clk);
    desc = d; len = AW'(n); start[k] = 1'b1;
    seen = 1'b0; lat = 0;
    for (int t = 1; t <= BOUND && !seen; t++) begin
      @(negedge clk);
      if (t == 1) start[k] = 1'b0;
      if (poke == 1 && t == 3) start[k] = 1'b1;
      if (poke == 1 && t == 4) start[k] = 1'b0;
      if (done[k] === 1'b1) begin
        seen = 1'b1;
        lat  = t;
      end
    end
    e = exp_q.pop_front();
    check({tag, " done_seen"}, longint'(seen), 1);
    check({tag, " latency"}, lat, e.lat);
    check({tag, " passes_o"}, longint'(passes[k]), e.passes);
    check({tag, " swaps_o"}, longint'(swaps[k]), e.swaps);
    if (poke == 2) begin
      start[k] = 1'b1;
      @(negedge clk);
    end
    start[k] = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, " busy_after"}, longint'(busy[k]), 0);
    check({tag, " done_count"}, done_cnt[k] - d0, 1);
    bad = -1;
    for (int i = 0; i < 32; i++)
      if (bad < 0 && int'(mem[k][i]) != exp_mem[i]) bad = i;
    check({tag, " ram_first_bad_index"}, bad, -1);
  endtask

  initial begin
    int nw, d0;
    srst = 1'b1; start[0] = 1'b0; start[1] = 1'b0; desc = 1'b0; len = '0;
    ld_en = 1'b0; ld_k = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d busy", k), longint'(busy[k]), 0);
      check($sformatf("rst%0d done", k), longint'(done[k]), 0);
      check($sformatf("rst%0d wren", k), longint'({wren_a[k], wren_b[k]}), 0);
      check($sformatf("rst%0d addr_a", k), longint'(addr_a[k]), 0);
      check($sformatf("rst%0d addr_b", k), longint'(addr_b[k]), 1);
      check($sformatf("rst%0d stats", k), longint'(passes[k]) + longint'(swaps[k]), 0);
    end
    srst = 1'b0;

    tbl[0] = mk(0, 0, 4, 0, w5(1, 2, 3, 4, 0), w5(1, 2, 3, 4, 0), 1, 0, 7);
    tbl[1] = mk(0, 0, 5, 1, w5(5, 4, 3, 2, 1), w5(1, 2, 3, 4, 5), 4, 10, 21);
    tbl[2] = mk(0, 1, 5, 2, w5(1, 2, 3, 4, 5), w5(5, 4, 3, 2, 1), 4, 10, 21);
    tbl[3] = mk(0, 0, 5, 0, w5(3, 1, 3, 1, 2), w5(1, 1, 2, 3, 3), 3, 5, 19);
    tbl[4] = mk(0, 0, 0, 0, w5(7, 3, 9, 0, 0), w5(7, 3, 9, 0, 0), 0, 0, 1);
    tbl[5] = mk(0, 0, 1, 2, w5(7, 3, 9, 0, 0), w5(7, 3, 9, 0, 0), 0, 0, 1);
    tbl[6] = mk(1, 0, 5, 0, w5(5, 4, 3, 2, 1), w5(1, 2, 3, 4, 5), 4, 10, 41);
    tbl[7] = mk(0, 0, 3, 0, w5(3, 2, 1, 9, 8), w5(1, 2, 3, 9, 8), 2, 3, 7);

    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i < 32; i++) stage[i] = (i < 8) ? int'(tbl[v].init[i]) : 0;
      load_ram(int'(tbl[v].k));
      run_sort($sformatf("vec%0d", v), int'(tbl[v].k), tbl[v].d, int'(tbl[v].n),
               int'(tbl[v].poke), 1'b0, int'(tbl[v].p), int'(tbl[v].s), int'(tbl[v].lat),
               tbl[v].expv);
    end
    check("no_write_on_equal", eq_wr, 0);

    for (int i = 0; i < 32; i++) stage[i] = int'($urandom_range(0, 63));
    load_ram(1);
    run_sort("rnd32_asc_lat3", 1, 1'b0, 32, 0, 1'b1, 0, 0, 0, '0);
    run_sort("rnd32_resort_desc_lat3", 1, 1'b1, 32, 0, 1'b1, 0, 0, 0, '0);
    for (int i = 0; i < 32; i++) stage[i] = int'($urandom_range(0, 63));
    load_ram(1);
    run_sort("rnd32_desc_lat3", 1, 1'b1, 32, 0, 1'b1, 0, 0, 0, '0);
    for (int i = 0; i < 32; i++) stage[i] = int'($urandom_range(0, 1023));
    load_ram(0);
    run_sort("rnd20_asc_lat1", 0, 1'b0, 20, 0, 1'b1, 0, 0, 0, '0);

    // Reset on the third swapping compare, then restart from the partial state.
    for (int i = 0; i < 32; i++) stage[i] = (i < 5) ? 5 - i : 0;
    load_ram(0);
    d0 = done_cnt[0];
    @(negedge clk);
    desc = 1'b0; len = AW'(5); start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    nw = 0;
    for (int t = 0; t < BOUND && nw < 3; t++) begin
      @(negedge clk);
      if (wren_a[0] === 1'b1) nw++;
    end
    check("midrst swap_reached", nw, 3);
    srst = 1'b1;
    @(negedge clk);
    check("midrst wren", longint'({wren_a[0], wren_b[0]}), 0);
    check("midrst busy", longint'(busy[0]), 0);
    check("midrst done", longint'(done[0]), 0);
    check("midrst stats", longint'(passes[0]) + longint'(swaps[0]), 0);
    srst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst no_done", done_cnt[0] - d0, 0);
    run_sort("restart_after_rst", 0, 1'b0, 5, 0, 1'b1, 0, 0, 0, '0);

    check("wren_a_b_equal", ab_mis, 0);
    check("no_write_when_idle", idle_wr, 0);
    check("no_write_on_equal_final", eq_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bubble_sort_ctrl.md
Name: bubble_sort_ctrl

Overview:
- Parametrised bubble-sort engine that sorts the first len_i words of an external true-dual-port RAM in place.
- Successor to the fixed single-mode sorter. Adds:
  - start/busy/done handshake;
  - ascending or descending mode;
  - early termination on a pass with no swaps;
  - configurable RAM read latency;
  - write-back only when a swap is needed;
  - pass/swap statistics.
- Sits between the packet-buffer RAM and the loader/unloader control in the sort subsystem.

Parameters:
DWIDTH, 10, data word width
ADDR_SZ, 10, RAM address width; maximum length 2**ADDR_SZ - 1
RD_LAT, 1, RAM read latency in cycles (1..4), address-register to q valid
CNT_W, 20, width of swap counter

Ports:
clk_i  in  1  clock; all logic on rising edge
srst_i  in  1  synchronous reset, active-high
start_i  in  1  start request; sampled only in IDLE
descending_i  in  1  sort order, captured at start: 0 ascending, 1 descending
len_i  in  ADDR_SZ  number of elements, captured at start
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse when sort complete
address_a  out  ADDR_SZ  RAM port A address (index i)
address_b  out  ADDR_SZ  RAM port B address (index i+1)
data_a  out  DWIDTH  RAM port A write data
data_b  out  DWIDTH  RAM port B write data
wren_a  out  1  RAM port A write enable
wren_b  out  1  RAM port B write enable
q_a  in  DWIDTH  RAM port A read data
q_b  in  DWIDTH  RAM port B read data
passes_o  out  ADDR_SZ  passes executed in last/current sort
swaps_o  out  CNT_W  swaps performed in last/current sort, saturating

Behaviour:
- Reset values:
  - state IDLE; busy_o, done_o, wren_a, wren_b = 0;
  - index, address_a = 0; address_b = 1;
  - passes_o, swaps_o = 0.
- A reset mid-sort aborts immediately: no further writes, no done_o, RAM left partially sorted.
- States: IDLE, READ, WAIT, CMP, DONE.
- IDLE:
  - start_i=1 captures len_i into len_r and descending_i into desc_r.
  - It sets last = len_i-1, index = 0, swapped = 0, and clears passes_o and swaps_o.
  - If len_i <= 1, go to DONE; otherwise go to READ.
- READ (1 cycle): addresses index and index+1 presented to the RAM. Addresses are held constant from READ through CMP.
- WAIT: RD_LAT-1 cycles (skipped when RD_LAT=1). CMP is therefore exactly RD_LAT cycles after READ.
- CMP (1 cycle): q_a and q_b are valid.
  - Swap condition: desc_r=0 → q_a > q_b; desc_r=1 → q_a < q_b. Equal values never swap (stable), unsigned compare.
  - On swap: wren_a = wren_b = 1, data_a = q_b, data_b = q_a, swapped <= 1, swaps_o increments (saturates at all-ones).
  - With no swap: wren = 0 and data_a/data_b = q_a/q_b (don't-care).
  - wren_a and wren_b are high only in CMP and only on a swap.
  - If index+1 < last: index++, go to READ.
  - Otherwise the pass ends and passes_o increments. If last == 1 or the pass had no swap (swapped, including the current compare), go to DONE. Otherwise last--, index = 0, swapped = 0, go to READ.
- DONE (1 cycle): done_o = 1, busy_o = 1, then IDLE. The statistics outputs hold their values until the next start.
- start_i while busy_o=1 is ignored. start_i in the DONE cycle is ignored.
- Compare cost is RD_LAT+1 cycles. A pass over last+1 elements costs last*(RD_LAT+1) cycles.
- Latency from the start sample edge to done_o = (total compares)*(RD_LAT+1) + 1 cycles. If len ≤ 1, done_o is high in the cycle after start.
- The write in CMP and the read in the following READ target overlapping addresses on different cycles. The RAM must return the new data (standard altsyncram registered read).
- len_i = 2**ADDR_SZ-1 (max) must work without index overflow; index+1 is computed at ADDR_SZ+1 bits.

Test Plan:
1. Reset, then RD_LAT=1, ascending, len=4, RAM [1,2,3,4] → 1 pass, 0 swaps, no wren ever, done_o at cycle 7 after start, passes_o=1, swaps_o=0.
2. Ascending, len=5, RAM [5,4,3,2,1] → RAM [1,2,3,4,5], swaps_o=10, passes_o=4, done_o exactly once; repeat with descending_i=1 on [1,2,3,4,5] → [5,4,3,2,1], swaps_o=10.
3. Duplicates and stability: ascending [3,1,3,1,2] → [1,1,2,3,3]; wren never asserted on any compare of equal values.
4. len_i=0 and len_i=1 → done_o pulse one cycle after start, RAM untouched, passes_o=0. start_i pulsed while busy → ignored, the single done_o count is unchanged.
5. RD_LAT=3, random 32-element array, both modes → result matches the reference model sort. Each compare spans 4 cycles with addresses stable; done latency = compares*4+1.
6. srst_i asserted mid-pass (during CMP with a swap pending) → wren low next cycle, busy_o=0, no done_o. A new start then sorts the array correctly from its partial state.
